// File: rtl/reg_writeback_unit_if.sv
// Bundle of the ALU/memory writeback sources and the register-file write port.
// The unit uses the slave view; the producer/consumer side uses master.
interface reg_writeback_unit_if #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned DW    = 32,
  parameter int unsigned AW    = 5
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic          AluValid;
  logic [AW-1:0] AluRd;
  logic [DW-1:0] AluData;
  logic          AluStall;

  logic          MemValid;
  logic [AW-1:0] MemRd;
  logic [DW-1:0] MemData;
  logic          MemReady;

  logic [AW-1:0] RD;
  logic [DW-1:0] WData;
  logic          RegWr;
  logic [31:0]   PendMask;
  logic [CW-1:0] Count;

  modport slave (
    input  AluValid, AluRd, AluData,
    input  MemValid, MemRd, MemData,
    output AluStall, MemReady,
    output RD, WData, RegWr, PendMask, Count
  );

  modport master (
    output AluValid, AluRd, AluData,
    output MemValid, MemRd, MemData,
    input  AluStall, MemReady,
    input  RD, WData, RegWr, PendMask, Count
  );
endinterface

// File: rtl/reg_writeback_unit.sv
// Merges ALU results and FIFO-buffered memory results onto the single registered
// register-file write port, and exports the mask of registers with queued writes.
module reg_writeback_unit #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned DW    = 32,
  parameter int unsigned AW    = 5
) (
  input  logic                  Clk,
  input  logic                  Reset,
  reg_writeback_unit_if.slave   bus
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_ALU,
    SEL_FIFO
  } sel_e;

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  logic [PW:0]      r_wptr;
  logic [PW:0]      r_rptr;
  logic [AW-1:0]    r_frd   [DEPTH];
  logic [DW-1:0]    r_fdata [DEPTH];
  logic [DEPTH-1:0] r_fvld;

  logic [AW-1:0]    r_rd;
  logic [DW-1:0]    r_wdata;
  logic             r_regwr;

  logic [CW-1:0]    w_count;
  logic [PW-1:0]    w_widx;
  logic [PW-1:0]    w_ridx;
  logic             w_full;
  logic             w_empty;
  logic             w_memready;
  logic             w_push;
  logic             w_pop;
  sel_e             w_sel;
  logic [31:0]      w_pend;

  assign w_count    = r_wptr - r_rptr;
  assign w_widx     = r_wptr[PW-1:0];
  assign w_ridx     = r_rptr[PW-1:0];
  assign w_full     = (w_count == CW'(DEPTH));
  assign w_empty    = (w_count == '0);

  // Readiness looks only at registered occupancy, never at this cycle's pop.
  assign w_memready = !Reset && !w_full;
  assign w_push     = bus.MemValid && w_memready && (bus.MemRd != '0);

  always_comb begin
    w_sel = SEL_NONE;
    if (w_full)
      w_sel = SEL_FIFO;
    else if (bus.AluValid)
      w_sel = SEL_ALU;
    else if (!w_empty)
      w_sel = SEL_FIFO;
  end

  assign w_pop = (w_sel == SEL_FIFO);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_fvld <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + CW'(1);
      if (w_pop)  r_rptr <= r_rptr + CW'(1);
      // Pop and push slots can only coincide when empty or full, where one side is idle.
      if (w_pop)  r_fvld[w_ridx] <= 1'b0;
      if (w_push) r_fvld[w_widx] <= 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (w_push) begin
      r_frd[w_widx]   <= bus.MemRd;
      r_fdata[w_widx] <= bus.MemData;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_rd    <= '0;
      r_wdata <= '0;
      r_regwr <= 1'b0;
    end else begin
      r_regwr <= 1'b0;
      case (w_sel)
        SEL_ALU: begin
          if (bus.AluRd != '0) begin
            r_regwr <= 1'b1;
            r_rd    <= bus.AluRd;
            r_wdata <= bus.AluData;
          end
        end
        SEL_FIFO: begin
          r_regwr <= 1'b1;
          r_rd    <= r_frd[w_ridx];
          r_wdata <= r_fdata[w_ridx];
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_pend = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (r_fvld[i]) w_pend[r_frd[i]] = 1'b1;
    end
  end

  assign bus.AluStall = bus.AluValid && w_full;
  assign bus.MemReady = w_memready;
  assign bus.RD       = r_rd;
  assign bus.WData    = r_wdata;
  assign bus.RegWr    = r_regwr;
  assign bus.PendMask = w_pend;
  assign bus.Count    = w_count;
endmodule

// File: tb/tb_reg_writeback_unit.sv
// Directed bench for reg_writeback_unit: expected port writes are queued as stimulus
// is driven and compared in order as RegWr pulses appear.
module tb_reg_writeback_unit;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 5;

  logic Clk;
  logic Reset;
  int   checks = 0;
  int   errors = 0;

  logic [AW+DW-1:0] exp_q[$];

  reg_writeback_unit_if #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) bus ();

  reg_writeback_unit #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Write-port monitor: every RegWr pulse must match the next expected write.
  always @(negedge Clk) begin
    logic [AW+DW-1:0] e;
    if (!Reset && bus.RegWr === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL unexpected_write: got rd=%0d data=%0h expected no write", bus.RD, bus.WData);
      end else begin
        e = exp_q.pop_front();
        check("wr_rd",   64'(bus.RD),    64'(e[AW+DW-1:DW]));
        check("wr_data", 64'(bus.WData), 64'(e[DW-1:0]));
      end
    end
  end

  task automatic wait_drain(input string tag);
    int n = 0;
    while ((bus.Count != 0 || exp_q.size() != 0) && n < 30) begin
      @(negedge Clk);
      n++;
    end
    check({tag, "_count"}, 64'(bus.Count), 64'(0));
    check({tag, "_queue"}, 64'(exp_q.size()), 64'(0));
  endtask

  initial begin
    logic [AW-1:0] rd_tab [4];
    logic [31:0]   pend_tab [4];
    rd_tab   = '{5'd5, 5'd6, 5'd5, 5'd7};
    pend_tab = '{32'h20, 32'h40, 32'h20, 32'h80};

    Reset        = 1'b1;
    bus.AluValid = 1'b0;
    bus.AluRd    = '0;
    bus.AluData  = '0;
    bus.MemValid = 1'b0;
    bus.MemRd    = '0;
    bus.MemData  = '0;

    // Reset values
    repeat (2) @(negedge Clk);
    check("rst_regwr",    64'(bus.RegWr),    64'(0));
    check("rst_rd",       64'(bus.RD),       64'(0));
    check("rst_wdata",    64'(bus.WData),    64'(0));
    check("rst_count",    64'(bus.Count),    64'(0));
    check("rst_pend",     64'(bus.PendMask), 64'(0));
    check("rst_memready", 64'(bus.MemReady), 64'(0));
    check("rst_alustall", 64'(bus.AluStall), 64'(0));
    Reset = 1'b0;

    repeat (5) begin
      @(negedge Clk);
      check("idle_regwr",    64'(bus.RegWr),    64'(0));
      check("idle_count",    64'(bus.Count),    64'(0));
      check("idle_memready", 64'(bus.MemReady), 64'(1));
      check("idle_pend",     64'(bus.PendMask), 64'(0));
    end

    // Single ALU write
    bus.AluValid = 1'b1;
    bus.AluRd    = 5'd3;
    bus.AluData  = 32'h1234_5678;
    exp_q.push_back({5'd3, 32'h1234_5678});
    #1 check("alu_stall", 64'(bus.AluStall), 64'(0));
    @(negedge Clk);
    bus.AluValid = 1'b0;
    check("alu_regwr", 64'(bus.RegWr), 64'(1));
    check("alu_rd",    64'(bus.RD),    64'(3));
    check("alu_wdata", 64'(bus.WData), 64'h1234_5678);
    @(negedge Clk);
    check("alu_once", 64'(bus.RegWr), 64'(0));

    // Four memory pushes with the ALU idle: drain as fast as they arrive
    for (int i = 0; i < 4; i++) begin
      bus.MemValid = 1'b1;
      bus.MemRd    = rd_tab[i];
      bus.MemData  = 32'hA0 + 32'(i);
      exp_q.push_back({rd_tab[i], 32'hA0 + 32'(i)});
      @(negedge Clk);
      check("mem_pend",  64'(bus.PendMask), 64'(pend_tab[i]));
      check("mem_count", 64'(bus.Count),    64'(1));
    end
    bus.MemValid = 1'b0;
    @(negedge Clk);
    check("mem_last_rd", 64'(bus.RD),       64'(7));
    check("mem_pend0",   64'(bus.PendMask), 64'(0));
    wait_drain("mem");

    // Fill with x0 ALU traffic holding off pops, then stall a real ALU write
    for (int i = 0; i < 4; i++) begin
      bus.AluValid = 1'b1;
      bus.AluRd    = '0;
      bus.AluData  = $urandom;
      bus.MemValid = 1'b1;
      bus.MemRd    = rd_tab[i];
      bus.MemData  = 32'hB0 + 32'(i);
      exp_q.push_back({rd_tab[i], 32'hB0 + 32'(i)});
      @(negedge Clk);
      check("fill_count", 64'(bus.Count), 64'(i + 1));
    end
    bus.MemRd   = 5'd8;
    bus.MemData = 32'hB4;
    bus.AluRd   = 5'd9;
    bus.AluData = 32'h99;
    exp_q.insert(1, {5'd9, 32'h99});
    exp_q.push_back({5'd8, 32'hB4});
    #1;
    check("full_memready", 64'(bus.MemReady), 64'(0));
    check("full_alustall", 64'(bus.AluStall), 64'(1));
    check("full_pend",     64'(bus.PendMask), 64'h0E0);
    @(negedge Clk);
    check("full_pop_rd",   64'(bus.RD),       64'(5));
    check("full_pop_data", 64'(bus.WData),    64'hB0);
    check("full_count3",   64'(bus.Count),    64'(3));
    check("full_ready3",   64'(bus.MemReady), 64'(1));
    check("full_stall3",   64'(bus.AluStall), 64'(0));
    check("full_pend5",    64'(bus.PendMask), 64'h0E0);
    @(negedge Clk);
    bus.AluValid = 1'b0;
    bus.MemValid = 1'b0;
    check("stalled_alu_rd",   64'(bus.RD),       64'(9));
    check("stalled_alu_data", 64'(bus.WData),    64'h99);
    check("refill_count",     64'(bus.Count),    64'(4));
    check("refill_pend",      64'(bus.PendMask), 64'h1E0);
    @(negedge Clk);
    check("pend_b1", 64'(bus.PendMask), 64'h1A0);
    @(negedge Clk);
    check("pend_b2_rd", 64'(bus.RD),       64'(5));
    check("pend_b2",    64'(bus.PendMask), 64'h180);
    wait_drain("full");

    // Steady push+pop at DEPTH-1 across several pointer wraps
    for (int i = 0; i < 3 * DEPTH; i++) begin
      if (i >= 4) check("wrap_count", 64'(bus.Count), 64'(DEPTH - 1));
      bus.AluValid = (i < 3);
      bus.AluRd    = '0;
      bus.MemValid = 1'b1;
      bus.MemRd    = 5'(16 + (i % 8));
      bus.MemData  = 32'hC000_0000 + 32'(i);
      exp_q.push_back({5'(16 + (i % 8)), 32'hC000_0000 + 32'(i)});
      @(negedge Clk);
    end
    check("wrap_count_end", 64'(bus.Count), 64'(DEPTH - 1));
    bus.MemValid = 1'b0;
    wait_drain("wrap");

    // x0 writes from both sources
    bus.AluValid = 1'b1;
    bus.AluRd    = '0;
    bus.AluData  = 32'hDEAD_BEEF;
    bus.MemValid = 1'b1;
    bus.MemRd    = '0;
    bus.MemData  = 32'hFEED_F00D;
    #1;
    check("x0_stall", 64'(bus.AluStall), 64'(0));
    check("x0_ready", 64'(bus.MemReady), 64'(1));
    @(negedge Clk);
    bus.AluValid = 1'b0;
    bus.MemValid = 1'b0;
    check("x0_regwr", 64'(bus.RegWr),    64'(0));
    check("x0_count", 64'(bus.Count),    64'(0));
    check("x0_pend",  64'(bus.PendMask), 64'(0));
    @(negedge Clk);
    check("x0_regwr2", 64'(bus.RegWr), 64'(0));

    // Reset mid-stream with three queued entries: none may emerge afterwards
    for (int i = 0; i < 3; i++) begin
      bus.AluValid = 1'b1;
      bus.AluRd    = '0;
      bus.MemValid = 1'b1;
      bus.MemRd    = 5'(11 + i);
      bus.MemData  = 32'hE0 + 32'(i);
      @(negedge Clk);
    end
    check("pre_rst_count", 64'(bus.Count),    64'(3));
    check("pre_rst_pend",  64'(bus.PendMask), 64'h3800);
    #2;
    Reset        = 1'b1;
    bus.AluValid = 1'b0;
    bus.MemValid = 1'b0;
    #1;
    check("mid_rst_count", 64'(bus.Count),    64'(0));
    check("mid_rst_pend",  64'(bus.PendMask), 64'(0));
    check("mid_rst_ready", 64'(bus.MemReady), 64'(0));
    check("mid_rst_regwr", 64'(bus.RegWr),    64'(0));
    check("mid_rst_rd",    64'(bus.RD),       64'(0));
    check("mid_rst_wdata", 64'(bus.WData),    64'(0));
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    repeat (6) begin
      @(negedge Clk);
      check("post_rst_regwr", 64'(bus.RegWr),    64'(0));
      check("post_rst_count", 64'(bus.Count),    64'(0));
      check("post_rst_pend",  64'(bus.PendMask), 64'(0));
    end
    check("post_rst_ready", 64'(bus.MemReady), 64'(1));
    check("final_queue",    64'(exp_q.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
